// File: rtl/int_div_unit.sv
// Iterative RV32M divide unit: restoring division, one quotient bit per cycle,
// with DIV/DIVU/REM/REMU results delivered on the register-file write port.
module int_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    neg_if = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   quo_r, rem_r, divisor_r;
  logic              is_rem_r, qneg_r, rneg_r;
  logic [4:0]        dst_r;
  logic              wb_we_r;
  logic [4:0]        wb_addr_r;
  logic [XLEN-1:0]   wb_data_r;

  logic              accept_s, is_signed_s, a_neg_s, b_neg_s;
  logic              div0_s, ovf_s, special_s, ge_s;
  logic [XLEN:0]     trial_s, diff_s;
  logic [XLEN-1:0]   result_s;

  assign start_ready = (state_r == ST_IDLE) && !flush;
  assign busy        = (state_r != ST_IDLE);
  assign accept_s    = start_valid && start_ready;

  assign is_signed_s = ~op[0];
  assign a_neg_s     = is_signed_s & rs1_data[XLEN-1];
  assign b_neg_s     = is_signed_s & rs2_data[XLEN-1];
  assign div0_s      = (rs2_data == {XLEN{1'b0}});
  assign ovf_s       = is_signed_s && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (rs2_data == {XLEN{1'b1}});
  assign special_s   = div0_s | ovf_s;

  // A borrow out of the trial subtraction means the divisor did not fit
  assign trial_s  = {rem_r, quo_r[XLEN-1]};
  assign diff_s   = trial_s - {1'b0, divisor_r};
  assign ge_s     = ~diff_s[XLEN];
  assign result_s = is_rem_r ? neg_if(rem_r, rneg_r) : neg_if(quo_r, qneg_r);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = special_s ? ST_DONE : ST_CALC;
        else          state_nxt_s = ST_IDLE;
      end
      ST_CALC: begin
        if (flush)                     state_nxt_s = ST_IDLE;
        else if (cnt_r == {CW{1'b0}})  state_nxt_s = ST_DONE;
        else                           state_nxt_s = ST_CALC;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture at accept and one restoring step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      divisor_r <= {XLEN{1'b0}};
      is_rem_r  <= 1'b0;
      qneg_r    <= 1'b0;
      rneg_r    <= 1'b0;
      dst_r     <= 5'd0;
    end else if (accept_s) begin
      cnt_r     <= CW'(XLEN-1);
      is_rem_r  <= op[1];
      dst_r     <= rd_addr_in;
      divisor_r <= neg_if(rs2_data, b_neg_s);
      // Special cases preload the final result with sign fix-up disabled
      if (div0_s) begin
        quo_r  <= {XLEN{1'b1}};
        rem_r  <= rs1_data;
        qneg_r <= 1'b0;
        rneg_r <= 1'b0;
      end else if (ovf_s) begin
        quo_r  <= {1'b1, {(XLEN-1){1'b0}}};
        rem_r  <= {XLEN{1'b0}};
        qneg_r <= 1'b0;
        rneg_r <= 1'b0;
      end else begin
        quo_r  <= neg_if(rs1_data, a_neg_s);
        rem_r  <= {XLEN{1'b0}};
        qneg_r <= a_neg_s ^ b_neg_s;
        rneg_r <= a_neg_s;
      end
    end else if (state_r == ST_CALC) begin
      rem_r <= ge_s ? diff_s[XLEN-1:0] : trial_s[XLEN-1:0];
      quo_r <= {quo_r[XLEN-2:0], ge_s};
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Writeback port; x0 destinations complete silently and leave the port unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_r   <= 1'b0;
      wb_addr_r <= 5'd0;
      wb_data_r <= {XLEN{1'b0}};
    end else if ((state_r == ST_DONE) && (dst_r != 5'd0)) begin
      wb_we_r   <= 1'b1;
      wb_addr_r <= dst_r;
      wb_data_r <= result_s;
    end else begin
      wb_we_r   <= 1'b0;
    end
  end

  assign rd_we   = wb_we_r;
  assign rd_addr = wb_addr_r;
  assign rd_data = wb_data_r;

endmodule
